commit_trace_emitter: RTL and testbench

COMMIT_TRACE_EMITTER -- requirements
Module: commit_trace_emitter

---
 rtl/trace_pkg.sv | 17 +
 rtl/trace_fifo.sv | 69 ++++++
 rtl/commit_trace_emitter.sv | 114 +++++++++++
 tb/tb_commit_trace_emitter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared record type and default sizing for the commit trace emitter.
package trace_pkg;

  localparam int unsigned PC_W            = 32;
  localparam int unsigned INST_W          = 32;
  localparam int unsigned IDX_W           = 16;
  localparam int unsigned DEF_FIFO_DEPTH  = 8;
  localparam int unsigned DEF_HIST_DEPTH  = 5;
  localparam int unsigned DEF_MAX_RECORDS = 5000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [IDX_W-1:0]  index;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with a registered head, registered valid and occupancy.
// Pushes into a full FIFO are dropped unless a pop happens on the same edge.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  trace_rec_t       wdata,
  input  logic             ready,
  output logic             valid,
  output trace_rec_t       head,
  output logic [LVL_W-1:0] level,
  output logic             drop_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  trace_rec_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [LVL_W-1:0] remain;
  logic [LVL_W-1:0] level_nxt;
  logic             pop;
  logic             push_ok;

  always_comb begin
    pop        = valid & ready;
    push_ok    = push & ((level != LVL_W'(DEPTH)) | pop);
    drop_c     = push & ~push_ok;
    remain     = level - LVL_W'(pop);
    level_nxt  = remain + LVL_W'(push_ok);
    rd_ptr_nxt = rd_ptr + PTR_W'(pop);
  end

  // Head register: a push into an (effectively) empty FIFO bypasses straight to it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      level <= level_nxt;
      valid <= (level_nxt != '0);
      if (push_ok && (remain == '0)) begin
        head <= wdata;
      end else if (pop && (remain != '0)) begin
        head <= mem[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/commit_trace_emitter.sv
// Turns a stream of fetch PCs into indexed commit trace records via a PC-change history.
// Optional TRACE_DROP_CNT_EN adds a saturating drop_cnt output.
module commit_trace_emitter
  import trace_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned HIST_DEPTH  = DEF_HIST_DEPTH,
  parameter int unsigned MAX_RECORDS = DEF_MAX_RECORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc,
  input  logic [INST_W-1:0] inst,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [PC_W-1:0]   rec_pc,
  output logic [INST_W-1:0] rec_inst,
  output logic [IDX_W-1:0]  rec_index,
  output logic              cpu_stall,
  output logic              done
`ifdef TRACE_DROP_CNT_EN
  ,
  output logic [IDX_W-1:0]  drop_cnt
`endif
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

  logic [PC_W-1:0]   hist_pc   [HIST_DEPTH];
  logic [INST_W-1:0] hist_inst [HIST_DEPTH];
  logic [IDX_W-1:0]  count;
  logic [IDX_W-1:0]  count_inc;
  logic [IDX_W-1:0]  idx_q;
  logic              push_q;
  logic              shift;
  logic              req;
  logic              pop;
  logic              drop;
  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  level_nxt;
  trace_rec_t        wdata;
  trace_rec_t        head;

  always_comb begin
    shift     = (pc != hist_pc[0]);
    req       = shift && (hist_pc[HIST_DEPTH-2] != '0) && !done;
    count_inc = count + IDX_W'(1);
    pop       = rec_valid & rec_ready;
    level_nxt = level - LVL_W'(pop) + LVL_W'(push_q & ~drop);
    wdata     = '{pc: hist_pc[HIST_DEPTH-1], inst: hist_inst[HIST_DEPTH-1], index: idx_q};
  end

  // The record enters the FIFO one edge after the shift that brought it to the oldest slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_pc[i]   <= '0;
        hist_inst[i] <= '0;
      end
      count     <= '0;
      idx_q     <= '0;
      push_q    <= 1'b0;
      done      <= 1'b0;
      cpu_stall <= 1'b0;
    end else begin
      if (shift) begin
        hist_pc[0]   <= pc;
        hist_inst[0] <= inst;
        for (int i = 1; i < HIST_DEPTH; i++) begin
          hist_pc[i]   <= hist_pc[i-1];
          hist_inst[i] <= hist_inst[i-1];
        end
      end
      push_q <= req;
      if (req) begin
        idx_q <= count;
        count <= count_inc;
        if (count_inc == IDX_W'(MAX_RECORDS)) begin
          done <= 1'b1;
        end
      end
      cpu_stall <= (level_nxt >= LVL_W'(FIFO_DEPTH - 1));
    end
  end

  trace_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push_q),
    .wdata  (wdata),
    .ready  (rec_ready),
    .valid  (rec_valid),
    .head   (head),
    .level  (level),
    .drop_c (drop)
  );

  assign rec_pc    = head.pc;
  assign rec_inst  = head.inst;
  assign rec_index = head.index;

`ifdef TRACE_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + IDX_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_commit_trace_emitter.sv
// Directed bench for commit_trace_emitter: vector table plus multi-cycle corner sequences.
// Honors TRACE_DROP_CNT_EN when the design is built with it.
module tb_commit_trace_emitter;
  import trace_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        rec_ready;
  logic [31:0] pc;
  logic [31:0] inst;

  logic        a_valid, a_stall, a_done;
  logic [31:0] a_pc, a_inst;
  logic [15:0] a_idx;
  logic        b_valid, b_stall, b_done;
  logic [31:0] b_pc, b_inst;
  logic [15:0] b_idx;
`ifdef TRACE_DROP_CNT_EN
  logic [15:0] a_drop, b_drop;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  commit_trace_emitter u_a (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .inst      (inst),
    .rec_valid (a_valid),
    .rec_ready (rec_ready),
    .rec_pc    (a_pc),
    .rec_inst  (a_inst),
    .rec_index (a_idx),
    .cpu_stall (a_stall),
    .done      (a_done)
`ifdef TRACE_DROP_CNT_EN
    ,
    .drop_cnt  (a_drop)
`endif
  );

  commit_trace_emitter #(
    .MAX_RECORDS (3)
  ) u_b (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .inst      (inst),
    .rec_valid (b_valid),
    .rec_ready (rec_ready),
    .rec_pc    (b_pc),
    .rec_inst  (b_inst),
    .rec_index (b_idx),
    .cpu_stall (b_stall),
    .done      (b_done)
`ifdef TRACE_DROP_CNT_EN
    ,
    .drop_cnt  (b_drop)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic [31:0] pc;
    logic        rdy;
    logic        valid;
    logic        chk;
    logic [31:0] rpc;
    logic [15:0] ridx;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] inst_of(input logic [31:0] p);
    return p ^ 32'hC0DE_0000;
  endfunction

  task automatic add(input logic r, input logic [31:0] p, input logic v,
                     input logic c, input logic [31:0] rp, input logic [15:0] ri);
    vec_t t;
    t.rst_n = r; t.pc = p; t.rdy = 1'b1; t.valid = v; t.chk = c; t.rpc = rp; t.ridx = ri;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] p, input logic rdy);
    reset     = r;
    pc        = p;
    inst      = inst_of(p);
    rec_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int delivered;
    logic [15:0] drain_idx [7];
    logic [31:0] last_pc;

    drive(1'b0, 32'h0, 1'b1);

    // Fill, first record, hold at 0x20, then resume.
    for (int i = 0; i < 3; i++) add(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 16'd0);
    add(1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 16'd0);
    add(1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 16'd0);
    add(1'b1, 32'h0C, 1'b0, 1'b0, 32'h0, 16'd0);
    add(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 16'd0);
    add(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 16'd0);
    add(1'b1, 32'h18, 1'b1, 1'b1, 32'h04, 16'd0);
    add(1'b1, 32'h20, 1'b1, 1'b1, 32'h08, 16'd1);
    add(1'b1, 32'h20, 1'b1, 1'b1, 32'h0C, 16'd2);
    for (int i = 0; i < 8; i++) add(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 16'd0);
    add(1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 16'd0);
    add(1'b1, 32'h28, 1'b1, 1'b1, 32'h10, 16'd3);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].pc, vecs[i].rdy);
      step();
      check($sformatf("vec%0d_valid", i), a_valid, vecs[i].valid);
      check($sformatf("vec%0d_stall", i), a_stall, 1'b0);
      check($sformatf("vec%0d_done", i), a_done, 1'b0);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_pc", i), a_pc, vecs[i].rpc);
        check($sformatf("vec%0d_idx", i), a_idx, vecs[i].ridx);
        check($sformatf("vec%0d_inst", i), a_inst, vecs[i].rpc == 0 ? 32'h0 : inst_of(vecs[i].rpc));
      end
    end

    // Backpressure: stall after the 7th enqueue, 9th dropped, push+pop at full.
    drive(1'b0, 32'h0, 1'b0);
    repeat (3) step();
    for (int k = 1; k <= 14; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 1'b0);
      step();
      if (k == 11) check("stall_before_7th", a_stall, 1'b0);
      if (k == 12) check("stall_after_7th", a_stall, 1'b1);
    end
    check("full_valid", a_valid, 1'b1);
    check("full_head_idx", a_idx, 16'd0);
    check("full_stall", a_stall, 1'b1);
`ifdef TRACE_DROP_CNT_EN
    check("drop_cnt_one", a_drop, 16'd1);
`endif
    drive(1'b1, 32'h138, 1'b1);
    step();
    check("pushpop_full_idx", a_idx, 16'd1);
    check("pushpop_full_stall", a_stall, 1'b1);
`ifdef TRACE_DROP_CNT_EN
    check("pushpop_no_drop", a_drop, 16'd1);
`endif
    drain_idx = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd9};
    for (int j = 0; j < 7; j++) begin
      step();
      check($sformatf("drain%0d_valid", j), a_valid, 1'b1);
      check($sformatf("drain%0d_idx", j), a_idx, drain_idx[j]);
      check($sformatf("drain%0d_stall", j), a_stall, j == 0 ? 1'b1 : 1'b0);
      check($sformatf("drain%0d_pc", j), a_pc, 32'h100 + 32'(4 * (drain_idx[j] + 16'd1)));
    end
    step();
    check("drain_empty", a_valid, 1'b0);

    // Reset with records queued discards them; indices restart at 0.
    drive(1'b0, 32'h0, 1'b0);
    repeat (2) step();
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, 32'h200 + 32'(4 * k), 1'b0);
      step();
    end
    check("queued_valid", a_valid, 1'b1);
    drive(1'b0, 32'h224, 1'b0);
    step();
    check("midreset_valid", a_valid, 1'b0);
    check("midreset_pc", a_pc, 32'h0);
    check("midreset_idx", a_idx, 16'd0);
    check("midreset_stall", a_stall, 1'b0);
    step();
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 32'h300 + 32'(4 * k), 1'b1);
      step();
      if (k == 5) check("restart_not_yet", a_valid, 1'b0);
    end
    check("restart_valid", a_valid, 1'b1);
    check("restart_idx", a_idx, 16'd0);
    check("restart_pc", a_pc, 32'h304);
    check("restart_in_flight_gone", a_done, 1'b0);

    // MAX_RECORDS=3 instance: done after the 3rd enqueue, exactly 3 delivered.
    drive(1'b0, 32'h0, 1'b1);
    repeat (2) step();
    delivered = 0;
    last_pc   = 32'h0;
    for (int k = 1; k <= 14; k++) begin
      drive(1'b1, k <= 10 ? 32'h400 + 32'(4 * k) : 32'h428, 1'b1);
      step();
      if (b_valid) begin
        check($sformatf("max_idx%0d", delivered), b_idx, 16'(delivered));
        check($sformatf("max_pc%0d", delivered), b_pc, 32'h404 + 32'(4 * delivered));
        last_pc = b_inst;
        delivered++;
      end
      if (k == 6) check("done_before_3rd", b_done, 1'b0);
      if (k == 7) check("done_after_3rd", b_done, 1'b1);
    end
    check("max_delivered", 32'(delivered), 32'd3);
    check("max_last_inst", last_pc, inst_of(32'h40C));
    check("max_done_sticky", b_done, 1'b1);
    check("max_stall", b_stall, 1'b0);
    check("default_not_done", a_done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
